// File: rtl/double_dabble_sequential.sv
// double_dabble_sequential
//   Multi-cycle binary-to-BCD converter (shift-and-add-3). One operand bit is
//   consumed per clock, so a conversion takes INPUT_BITS clocks after Start_i
//   is accepted in IDLE.
//
// Parameters
//   INPUT_BITS    width of Binary_i (>= 2)
//   OUTPUT_DIGITS number of BCD digits in BCD_o
//
// Ports
//   Clock       rising-edge clock
//   Reset       synchronous, active-high reset
//   Start_i     conversion request, sampled only in IDLE
//   Signed_i    1 = Binary_i is two's complement (sampled with Start_i)
//   Binary_i    operand (sampled with Start_i)
//   Busy_o      high while a conversion is in progress
//   Done_o      one-cycle pulse when the result registers update
//   BCD_o       result, digit k at [4k+3:4k]; magnitude mod 10^OUTPUT_DIGITS
//   Negative_o  operand was negative (signed mode only)
//   Overflow_o  magnitude exceeded 10^OUTPUT_DIGITS - 1
module double_dabble_sequential #(
  parameter int INPUT_BITS    = 8,
  parameter int OUTPUT_DIGITS = 3
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Start_i,
  input  logic                       Signed_i,
  input  logic [INPUT_BITS-1:0]      Binary_i,
  output logic                       Busy_o,
  output logic                       Done_o,
  output logic [4*OUTPUT_DIGITS-1:0] BCD_o,
  output logic                       Negative_o,
  output logic                       Overflow_o
);

  localparam int OUTPUT_BITS = 4 * OUTPUT_DIGITS;
  localparam int CNT_W       = $clog2(INPUT_BITS + 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [INPUT_BITS-1:0]   mag_q, mag_d;
  logic [OUTPUT_BITS-1:0]  work_q, work_d;
  logic                    sign_q, sign_d;
  logic                    sticky_q, sticky_d;
  logic [OUTPUT_BITS-1:0]  bcd_q, bcd_d;
  logic                    neg_q, neg_d;
  logic                    ovf_q, ovf_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Work register after the per-digit add-3 correction.
  logic [OUTPUT_BITS-1:0]  adj;

  always_comb begin
    adj = '0;
    for (int unsigned k = 0; k < OUTPUT_DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
      end else begin
        adj[4*k +: 4] = work_q[4*k +: 4];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mag_d    = mag_q;
    work_d   = work_q;
    sign_d   = sign_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start_i) begin
          if (Signed_i && Binary_i[INPUT_BITS-1]) begin
            // Most negative value negates to itself, which is the correct
            // unsigned magnitude.
            mag_d  = ~Binary_i + INPUT_BITS'(1);
            sign_d = 1'b1;
          end else begin
            mag_d  = Binary_i;
            sign_d = 1'b0;
          end
          work_d   = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(INPUT_BITS);
          busy_d   = 1'b1;
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        work_d   = {adj[OUTPUT_BITS-2:0], mag_q[INPUT_BITS-1]};
        mag_d    = {mag_q[INPUT_BITS-2:0], 1'b0};
        // A carry out of the top digit means the value reached 10^digits;
        // the remaining digits still hold the value modulo 10^digits.
        sticky_d = sticky_q | adj[OUTPUT_BITS-1];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = work_d;
          neg_d   = sign_q;
          ovf_d   = sticky_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mag_q    <= '0;
      work_q   <= '0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mag_q    <= mag_d;
      work_q   <= work_d;
      sign_q   <= sign_d;
      sticky_q <= sticky_d;
      bcd_q    <= bcd_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy_o     = busy_q;
  assign Done_o     = done_q;
  assign BCD_o      = bcd_q;
  assign Negative_o = neg_q;
  assign Overflow_o = ovf_q;

endmodule

// File: tb/tb_double_dabble_sequential.sv
// Testbench for double_dabble_sequential: a 3-digit and a 2-digit instance
// share stimulus; results are compared against an arithmetic model.
module tb_double_dabble_sequential;

  logic        Clock;
  logic        Reset;
  logic        Start_i;
  logic        Signed_i;
  logic [7:0]  Binary_i;

  logic        busy3, done3, neg3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, neg2, ovf2;
  logic [7:0]  bcd2;

  int tests_run = 0;
  int fails     = 0;

  double_dabble_sequential #(.INPUT_BITS(8), .OUTPUT_DIGITS(3)) dut3 (
    .Clock(Clock), .Reset(Reset), .Start_i(Start_i), .Signed_i(Signed_i),
    .Binary_i(Binary_i), .Busy_o(busy3), .Done_o(done3), .BCD_o(bcd3),
    .Negative_o(neg3), .Overflow_o(ovf3)
  );

  double_dabble_sequential #(.INPUT_BITS(8), .OUTPUT_DIGITS(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .Start_i(Start_i), .Signed_i(Signed_i),
    .Binary_i(Binary_i), .Busy_o(busy2), .Done_o(done2), .BCD_o(bcd2),
    .Negative_o(neg2), .Overflow_o(ovf2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference: magnitude in plain integers, decimal digits by div/mod.
  function automatic void model(input logic [7:0] b, input logic s, input int digits,
                                output logic [11:0] bcd, output logic neg, output logic ovf);
    int mag;
    int lim;
    int r;
    mag = (s && b[7]) ? 256 - int'(b) : int'(b);
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    ovf = (mag >= lim);
    neg = s && b[7];
    r   = mag % lim;
    bcd = '0;
    for (int k = 0; k < digits; k++) begin
      bcd[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  // Stimulus: one-cycle start, then wait for Done of the 3-digit instance.
  // lat = clocks from the accepting edge to Done; bad = busy/done anomalies.
  task automatic do_conv(input logic [7:0] b, input logic s, output int lat, output int bad);
    @(negedge Clock);
    Binary_i = b;
    Signed_i = s;
    Start_i  = 1'b1;
    @(negedge Clock);
    Start_i  = 1'b0;
    bad = 0;
    if (!busy3 || done3) bad++;
    Binary_i = 8'($urandom);
    Signed_i = 1'($urandom);
    lat = 0;
    while (lat < 30) begin
      @(negedge Clock);
      lat++;
      if (done3) break;
      if (!busy3) bad++;
    end
    if (busy3) bad++;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start_i = 1'b0; Signed_i = 1'b0; Binary_i = '0;
    repeat (3) @(negedge Clock);
    tests_run++; if (bcd3 !== 12'h000) begin fails++; $display("FAIL reset_bcd3 got %h exp 000", bcd3); end
    tests_run++; if (busy3 !== 1'b0)   begin fails++; $display("FAIL reset_busy3 got %b exp 0", busy3); end
    tests_run++; if (done3 !== 1'b0)   begin fails++; $display("FAIL reset_done3 got %b exp 0", done3); end
    tests_run++; if (neg3 !== 1'b0)    begin fails++; $display("FAIL reset_neg3 got %b exp 0", neg3); end
    tests_run++; if (ovf3 !== 1'b0)    begin fails++; $display("FAIL reset_ovf3 got %b exp 0", ovf3); end
    tests_run++; if ({busy2, done2, neg2, ovf2, bcd2} !== 12'h000) begin
      fails++; $display("FAIL reset_dut2 got %b%b%b%b %h exp all 0", busy2, done2, neg2, ovf2, bcd2);
    end
    Reset = 1'b0;
  endtask

  task automatic test_unsigned_max();
    int lat, bad;
    do_conv(8'd255, 1'b0, lat, bad);
    tests_run++; if (lat !== 8)       begin fails++; $display("FAIL umax_latency got %0d exp 8", lat); end
    tests_run++; if (bad !== 0)       begin fails++; $display("FAIL umax_busy got %0d anomalies exp 0", bad); end
    tests_run++; if (bcd3 !== 12'h255) begin fails++; $display("FAIL umax_bcd got %h exp 255", bcd3); end
    tests_run++; if (neg3 !== 1'b0)   begin fails++; $display("FAIL umax_neg got %b exp 0", neg3); end
    tests_run++; if (ovf3 !== 1'b0)   begin fails++; $display("FAIL umax_ovf got %b exp 0", ovf3); end
    @(negedge Clock);
    tests_run++; if (done3 !== 1'b0)  begin fails++; $display("FAIL umax_done_pulse got %b exp 0", done3); end
    tests_run++; if (bcd3 !== 12'h255) begin fails++; $display("FAIL umax_hold got %h exp 255", bcd3); end
  endtask

  task automatic test_signed();
    logic [7:0] ops [3];
    logic [11:0] eb; logic en, eo;
    int lat, bad;
    ops[0] = 8'h80; ops[1] = 8'hFF; ops[2] = 8'h7F;
    for (int i = 0; i < 3; i++) begin
      do_conv(ops[i], 1'b1, lat, bad);
      model(ops[i], 1'b1, 3, eb, en, eo);
      tests_run++; if (bcd3 !== eb) begin fails++; $display("FAIL signed_bcd op=%h got %h exp %h", ops[i], bcd3, eb); end
      tests_run++; if (neg3 !== en) begin fails++; $display("FAIL signed_neg op=%h got %b exp %b", ops[i], neg3, en); end
      tests_run++; if (ovf3 !== eo) begin fails++; $display("FAIL signed_ovf op=%h got %b exp %b", ops[i], ovf3, eo); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] ops [3];
    logic [11:0] eb; logic en, eo;
    int lat, bad;
    ops[0] = 8'd255; ops[1] = 8'd99; ops[2] = 8'd100;
    for (int i = 0; i < 3; i++) begin
      do_conv(ops[i], 1'b0, lat, bad);
      model(ops[i], 1'b0, 2, eb, en, eo);
      tests_run++; if ({4'h0, bcd2} !== eb) begin fails++; $display("FAIL ovf_bcd op=%0d got %h exp %h", ops[i], bcd2, eb[7:0]); end
      tests_run++; if (ovf2 !== eo) begin fails++; $display("FAIL ovf_flag op=%0d got %b exp %b", ops[i], ovf2, eo); end
      tests_run++; if (done2 !== 1'b1) begin fails++; $display("FAIL ovf_done op=%0d got %b exp 1", ops[i], done2); end
    end
  endtask

  task automatic test_start_busy();
    int lat, dones;
    @(negedge Clock);
    Binary_i = 8'd200; Signed_i = 1'b0; Start_i = 1'b1;
    @(negedge Clock);
    Start_i = 1'b0;
    lat = 0;
    while (lat < 30) begin
      @(negedge Clock);
      lat++;
      Start_i = 1'b0;
      if (done3) break;
      if (lat == 3) begin Binary_i = 8'd7; Start_i = 1'b1; end
    end
    tests_run++; if (lat !== 8)        begin fails++; $display("FAIL busy_start_latency got %0d exp 8", lat); end
    tests_run++; if (bcd3 !== 12'h200) begin fails++; $display("FAIL busy_start_bcd got %h exp 200", bcd3); end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      if (done3 || busy3) dones++;
    end
    tests_run++; if (dones !== 0) begin fails++; $display("FAIL busy_start_extra got %0d busy/done cycles exp 0", dones); end
  endtask

  task automatic test_reset_mid();
    int lat, bad, dones;
    @(negedge Clock);
    Binary_i = 8'd123; Signed_i = 1'b0; Start_i = 1'b1;
    @(negedge Clock);
    Start_i = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    tests_run++; if ({busy3, done3, neg3, ovf3, bcd3} !== 16'h0000) begin
      fails++; $display("FAIL midreset_outputs got %b%b%b%b %h exp all 0", busy3, done3, neg3, ovf3, bcd3);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      if (done3) dones++;
    end
    tests_run++; if (dones !== 0) begin fails++; $display("FAIL midreset_done got %0d pulses exp 0", dones); end
    do_conv(8'd45, 1'b0, lat, bad);
    tests_run++; if (lat !== 8)        begin fails++; $display("FAIL midreset_relat got %0d exp 8", lat); end
    tests_run++; if (bcd3 !== 12'h045) begin fails++; $display("FAIL midreset_bcd got %h exp 045", bcd3); end
  endtask

  task automatic test_random();
    logic [7:0] b; logic s;
    logic [11:0] eb; logic en, eo;
    logic [11:0] eb2; logic en2, eo2;
    int lat, bad;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      s = 1'($urandom);
      do_conv(b, s, lat, bad);
      model(b, s, 3, eb, en, eo);
      model(b, s, 2, eb2, en2, eo2);
      tests_run++; if ({bcd3, neg3, ovf3} !== {eb, en, eo}) begin
        fails++; $display("FAIL rand3 op=%h s=%b got %h/%b/%b exp %h/%b/%b", b, s, bcd3, neg3, ovf3, eb, en, eo);
      end
      tests_run++; if ({4'h0, bcd2, neg2, ovf2} !== {eb2, en2, eo2}) begin
        fails++; $display("FAIL rand2 op=%h s=%b got %h/%b/%b exp %h/%b/%b", b, s, bcd2, neg2, ovf2, eb2[7:0], en2, eo2);
      end
      tests_run++; if (lat !== 8 || bad !== 0) begin
        fails++; $display("FAIL rand_timing op=%h got lat %0d bad %0d exp 8/0", b, lat, bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [512];
    logic [11:0] eb; logic en, eo;
    int gap;
    for (int i = 0; i < 256; i++) begin
      seq[i]       = 8'(i);
      seq[511 - i] = 8'(i);
    end
    @(negedge Clock);
    Signed_i = 1'b0; Binary_i = seq[0]; Start_i = 1'b1;
    for (int i = 0; i < 512; i++) begin
      gap = 0;
      while (gap < 30) begin
        @(negedge Clock);
        gap++;
        if (done3) break;
      end
      if (!done3) begin
        tests_run++; fails++;
        $display("FAIL b2b_timeout index=%0d got no done exp done", i);
        break;
      end
      if (i + 1 < 512) Binary_i = seq[i + 1];
      else Start_i = 1'b0;
      model(seq[i], 1'b0, 3, eb, en, eo);
      tests_run++; if ({bcd3, neg3, ovf3} !== {eb, en, eo}) begin
        fails++; $display("FAIL b2b_result op=%0d got %h exp %h", seq[i], bcd3, eb);
      end
      if (i > 0) begin
        tests_run++; if (gap !== 9) begin fails++; $display("FAIL b2b_spacing index=%0d got %0d exp 9", i, gap); end
      end
    end
    Start_i = 1'b0;
    @(negedge Clock);
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_overflow();
    test_start_busy();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
